// File: rtl/d7s_seq.sv
// Sequential binary-to-7-segment converter: iterative double-dabble behind a start/ready handshake,
// with leading-zero blanking, optional sign digit and overflow detection.
module d7s_seq #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int SIGNED      = 0,
  parameter int BLANK_ZEROS = 1,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      read_data,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg
);
  localparam int ND = (SIGNED != 0) ? DIGITS - 1 : DIGITS;
  localparam int BW = 4 * ND;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [7*DIGITS-1:0] BLANK_ALL = (ACTIVE_LOW != 0) ? {7*DIGITS{1'b1}} : {7*DIGITS{1'b0}};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [WIDTH-1:0]    r_mag, w_mag_in;
  logic [BW-1:0]       r_bcd, w_bcd_adj, w_bcd_nxt;
  logic                r_neg, r_ovf, w_carry, w_ovf_nxt;
  logic [CW-1:0]       r_cnt;
  logic [7*DIGITS-1:0] r_seg, w_seg;
  logic                r_overflow, w_accept, w_last, w_lead;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h3F;
      4'd1:    enc = 7'h06;
      4'd2:    enc = 7'h5B;
      4'd3:    enc = 7'h4F;
      4'd4:    enc = 7'h66;
      4'd5:    enc = 7'h6D;
      4'd6:    enc = 7'h7D;
      4'd7:    enc = 7'h07;
      4'd8:    enc = 7'h7F;
      4'd9:    enc = 7'h6F;
      default: enc = 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] pol(input logic [6:0] s);
    return (ACTIVE_LOW != 0) ? ~s : s;
  endfunction

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int k = 0; k < ND; k++)
      if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
    return r;
  endfunction

  assign w_mag_in  = (SIGNED != 0 && read_data[WIDTH-1]) ? ({WIDTH{1'b0}} - read_data) : read_data;
  assign w_accept  = start && ready;
  assign w_last    = (r_cnt == CW'(1));
  assign w_bcd_adj = add3(r_bcd);
  // The bit leaving the top BCD digit is the decimal carry that no longer fits.
  assign {w_carry, w_bcd_nxt} = {w_bcd_adj, r_mag[WIDTH-1]};
  assign w_ovf_nxt = r_ovf | w_carry;
  assign overflow  = r_overflow;
  assign seg       = r_seg;

  always_comb begin
    w_seg  = BLANK_ALL;
    w_lead = 1'b1;
    for (int k = ND - 1; k >= 0; k--) begin
      if (w_bcd_nxt[4*k +: 4] != 4'd0 || k == 0 || w_ovf_nxt || BLANK_ZEROS == 0) w_lead = 1'b0;
      w_seg[7*k +: 7] = pol(w_lead ? 7'h00 : enc(w_bcd_nxt[4*k +: 4]));
    end
    if (SIGNED != 0) w_seg[7*(DIGITS-1) +: 7] = pol(r_neg ? 7'h40 : 7'h00);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SHIFT;
      S_SHIFT: if (w_last)   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == S_IDLE) && !reset;
    busy  = (r_state == S_SHIFT) || (r_state == S_DONE);
    done  = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg      <= BLANK_ALL;
      r_overflow <= 1'b0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
      r_cnt <= CW'(WIDTH);
    end else if (r_state == S_SHIFT) begin
      r_ovf <= w_ovf_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_seg      <= w_seg;
        r_overflow <= w_ovf_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mag <= w_mag_in;
      r_neg <= (SIGNED != 0) && read_data[WIDTH-1];
      r_bcd <= '0;
    end else if (r_state == S_SHIFT) begin
      r_mag <= {r_mag[WIDTH-2:0], 1'b0};
      r_bcd <= w_bcd_nxt;
    end
  end
endmodule

// File: tb/tb_d7s_seq.sv
// Bench for d7s_seq: three configurations share stimulus; a scoreboard queue holds the expected
// display for every accepted start and is checked whenever done pulses.
module tb_d7s_seq;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       rdyA, bsyA, dnA, ovA, rdyB, bsyB, dnB, ovB, rdyC, bsyC, dnC, ovC;
  logic [20:0] segA;
  logic [13:0] segB;
  logic [27:0] segC;

  int checks = 0;
  int errors = 0;
  int dones  = 0;
  int accepts = 0;

  typedef struct {
    logic [7:0]  d;
    logic [20:0] segA; logic ovfA;
    logic [13:0] segB; logic ovfB;
    logic [27:0] segC; logic ovfC;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  d7s_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0), .BLANK_ZEROS(1), .ACTIVE_LOW(1)) dutA (
    .clk(clk), .reset(reset), .start(start), .read_data(data),
    .ready(rdyA), .busy(bsyA), .done(dnA), .overflow(ovA), .seg(segA));
  d7s_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(0), .BLANK_ZEROS(1), .ACTIVE_LOW(1)) dutB (
    .clk(clk), .reset(reset), .start(start), .read_data(data),
    .ready(rdyB), .busy(bsyB), .done(dnB), .overflow(ovB), .seg(segB));
  d7s_seq #(.WIDTH(8), .DIGITS(4), .SIGNED(1), .BLANK_ZEROS(1), .ACTIVE_LOW(1)) dutC (
    .clk(clk), .reset(reset), .start(start), .read_data(data),
    .ready(rdyC), .busy(bsyC), .done(dnC), .overflow(ovC), .seg(segC));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return t[d];
  endfunction

  // Decimal reference using integer division, independent of the shift-add algorithm.
  function automatic logic [27:0] mk(input logic [7:0] d, input int digits, input bit sgn, output logic ovf);
    int nd, mag, lim, v, p;
    bit neg;
    logic [27:0] s;
    nd  = sgn ? digits - 1 : digits;
    neg = sgn && d[7];
    mag = neg ? 256 - int'(d) : int'(d);
    lim = 1;
    for (int i = 0; i < nd; i++) lim *= 10;
    ovf = (mag >= lim);
    v = mag % lim;
    s = '1;
    p = 1;
    for (int k = 0; k < nd; k++) begin
      if (k == 0 || ovf || (v / p) != 0) s[7*k +: 7] = ~enc((v / p) % 10);
      p *= 10;
    end
    if (neg) s[7*(digits-1) +: 7] = ~7'h40;
    return s;
  endfunction

  function automatic vec_t model(input logic [7:0] d);
    vec_t e;
    logic [27:0] s;
    e.d = d;
    s = mk(d, 3, 1'b0, e.ovfA); e.segA = s[20:0];
    s = mk(d, 2, 1'b0, e.ovfB); e.segB = s[13:0];
    e.segC = mk(d, 4, 1'b1, e.ovfC);
    return e;
  endfunction

  // Scoreboard consumer: every done must match the oldest outstanding start.
  always @(negedge clk) begin
    if (dnA || dnB || dnC) begin
      vec_t e;
      dones++;
      chk("done_align", {dnA, dnB, dnC}, 3'b111);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("segA[%0d]", e.d), segA, e.segA);
        chk($sformatf("ovfA[%0d]", e.d), ovA, e.ovfA);
        chk($sformatf("segB[%0d]", e.d), segB, e.segB);
        chk($sformatf("ovfB[%0d]", e.d), ovB, e.ovfB);
        chk($sformatf("segC[%0d]", e.d), segC, e.segC);
        chk($sformatf("ovfC[%0d]", e.d), ovC, e.ovfC);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge (first SHIFT cycle).
  task automatic start_conv(input logic [7:0] d, input vec_t e, input bit push);
    int n = 0;
    while (!rdyA && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", rdyA, 1'b1);
    data  = d;
    start = 1'b1;
    if (push) sb.push_back(e);
    accepts++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
    while (!rdyA && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'd255, {7'h24, 7'h12, 7'h12}, 1'b0, {7'h12, 7'h12}, 1'b1, {7'h3F, 7'h7F, 7'h7F, 7'h79}, 1'b0};
    tbl[1] = '{8'd0,   {7'h7F, 7'h7F, 7'h40}, 1'b0, {7'h7F, 7'h40}, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0};
    tbl[2] = '{8'd105, {7'h79, 7'h40, 7'h12}, 1'b0, {7'h40, 7'h12}, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h12}, 1'b0};
    tbl[3] = '{8'd7,   {7'h7F, 7'h7F, 7'h78}, 1'b0, {7'h7F, 7'h78}, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 1'b0};
    tbl[4] = '{8'd42,  {7'h7F, 7'h19, 7'h24}, 1'b0, {7'h19, 7'h24}, 1'b0, {7'h7F, 7'h7F, 7'h19, 7'h24}, 1'b0};
    tbl[5] = '{8'h80,  {7'h79, 7'h24, 7'h00}, 1'b0, {7'h24, 7'h00}, 1'b1, {7'h3F, 7'h79, 7'h24, 7'h00}, 1'b0};
    tbl[6] = '{8'd200, {7'h24, 7'h40, 7'h40}, 1'b0, {7'h40, 7'h40}, 1'b1, {7'h3F, 7'h7F, 7'h12, 7'h02}, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_ready", {rdyA, rdyB, rdyC}, 3'b000);
    chk("rst_busy", {bsyA, bsyB, bsyC}, 3'b000);
    chk("rst_done", {dnA, dnB, dnC}, 3'b000);
    chk("rst_ovf", {ovA, ovB, ovC}, 3'b000);
    chk("rst_segA", segA, 21'h1FFFFF);
    chk("rst_segC", segC, 28'hFFFFFFF);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", rdyA, 1'b1);
    @(negedge clk);

    // Latency of 255: done exactly in the 9th cycle after accept, ready low throughout.
    start_conv(tbl[0].d, tbl[0], 1'b1);
    for (int i = 1; i <= 9; i++) begin
      chk($sformatf("lat_ready_c%0d", i), rdyA, 1'b0);
      chk($sformatf("lat_busy_c%0d", i), bsyA, 1'b1);
      chk($sformatf("lat_done_c%0d", i), dnA, (i == 9));
      if (i < 9) @(negedge clk);
    end
    @(negedge clk);
    chk("lat_ready_back", rdyA, 1'b1);
    chk("lat_done_low", dnA, 1'b0);
    chk("hold_segA", segA, tbl[0].segA);
    chk("hold_ovfB", ovB, 1'b1);

    for (int i = 1; i < 7; i++) start_conv(tbl[i].d, tbl[i], 1'b1);
    drain();

    // Start held high through a whole conversion: only the first is accepted.
    start_conv(tbl[4].d, tbl[4], 1'b1);
    for (int i = 0; i < 8; i++) begin
      start = 1'b1;
      data  = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    start = 1'b0;
    drain();
    chk("spam_done_count", dones, accepts);

    // Leave overflow set on B, then abort a conversion with reset at SHIFT cycle 4.
    start_conv(tbl[0].d, tbl[0], 1'b1);
    drain();
    start_conv(8'd99, tbl[0], 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_ready", rdyA, 1'b1);
    chk("abort_busy", bsyA, 1'b0);
    chk("abort_ovf", {ovA, ovB, ovC}, 3'b000);
    chk("abort_segA", segA, 21'h1FFFFF);
    chk("abort_segB", segB, 14'h3FFF);
    chk("abort_segC", segC, 28'hFFFFFFF);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (dnA) seen++;
      end
      chk("abort_no_done", seen, 0);
    end
    accepts--;
    start_conv(tbl[6].d, tbl[6], 1'b1);
    drain();

    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      start_conv(d, model(d), 1'b1);
    end
    drain();
    chk("total_done_count", dones, accepts);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/d7s_seq.md
Name: d7s_seq

Overview:
- Parametrised, sequential successor to the combinational 7-segment decoder. Converts an unsigned or two's-complement binary value of WIDTH bits into DIGITS 7-segment digit codes.
- Uses an iterative shift-add-3 (double-dabble) converter, one bit per clock, behind a start/ready handshake.
- Adds leading-zero blanking, a sign digit and overflow detection.
- Sits between the processor's data-memory read path and the board display pins. Its registered outputs hold stable between conversions.

Parameters:
- WIDTH, 8, input value width in bits (>=2).
- DIGITS, 3, number of displayed digit positions (>=1; >=2 when SIGNED=1).
- SIGNED, 0, 1 = read_data is two's complement and digit DIGITS-1 is reserved for the sign.
- BLANK_ZEROS, 1, 1 = leading zero digits are blanked; units digit is never blanked.
- ACTIVE_LOW, 1, 1 = segment outputs are inverted (common-anode).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion of read_data.
- read_data  input  WIDTH  value to display; sampled only on the accept edge.
- ready  output  1  high only in IDLE and when reset is low.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; seg and overflow are updated this cycle.
- overflow  output  1  registered; magnitude does not fit in the available decimal digits.
- seg  output  7*DIGITS  digit k occupies bits [7k+6:7k]; k=0 is units. Bit order within a digit is {g,f,e,d,c,b,a}.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; done=0, overflow=0, busy=0.
  - Every seg digit shows blank: all segments off, i.e. 7'h7F when ACTIVE_LOW=1 and 7'h00 otherwise.
  - ready=0 while reset is high.
  - Reset during SHIFT or DONE aborts the conversion; no done pulse is produced.
- Accept:
  - A conversion is accepted on a rising edge where start=1 and ready=1.
  - start is ignored in SHIFT and DONE; there is no queueing.
- Magnitude capture on the accept edge:
  - mag = read_data, or two's-complement negation when SIGNED=1 and read_data[WIDTH-1]=1.
  - mag is WIDTH bits unsigned, so the most negative value yields 2^(WIDTH-1) exactly.
  - The negative flag is captured with mag. BCD accumulator is cleared, iteration counter loads WIDTH, state goes to SHIFT.
- SHIFT, one iteration per cycle:
  - Add 3 to each BCD digit that is >=5.
  - Shift {bcd, mag} left by one.
  - A 1 shifted out of the top BCD digit sets a sticky overflow flag.
- BCD width:
  - ND = DIGITS when SIGNED=0, DIGITS-1 when SIGNED=1.
  - On overflow the retained digits equal mag mod 10^ND.
- Exit from SHIFT:
  - After exactly WIDTH SHIFT cycles the final edge registers seg and overflow and moves to DONE.
  - done=1 for that one cycle, then the state returns to IDLE.
  - Latency: accept edge E0, result registered at edge E(WIDTH), done high during cycle E(WIDTH)..E(WIDTH+1).
  - A new start may be accepted at the edge ending the first IDLE cycle.
- Encoding (active-high, before the ACTIVE_LOW inversion):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - minus=40 (segment g only), blank=00.
- Blanking (BLANK_ZEROS=1): digits above the most significant non-zero digit are blank. Interior zeros and the units digit are always drawn. When overflow=1, no blanking is applied.
- Sign digit (SIGNED=1): seg digit DIGITS-1 shows minus when the value is negative, otherwise blank. A negative-zero case cannot occur.
- Hold: seg and overflow hold their values until the next DONE or reset.

Test Plan:
- WIDTH=8, DIGITS=3, ACTIVE_LOW=1, read_data=255 -> exactly 8 cycles after accept: done=1, seg={24,12,12}, overflow=0. ready is low for 9 cycles after accept.
- read_data=0 -> seg={7F,7F,40}. read_data=105 -> seg={79,40,12}, interior zero kept. read_data=7 -> seg={7F,7F,78}.
- DIGITS=2, read_data=255 -> seg={12,12} (55), overflow=1. The next conversion of 42 -> overflow=0, seg={19,24}.
- SIGNED=1, DIGITS=4: read_data=8'h80 -> seg={3F,79,24,00} (-128). read_data=8'hFF -> seg={3F,7F,7F,79} (-  1).
- Pulse start every cycle during a conversion -> only the first is accepted; exactly one done per accepted start.
- Assert reset at SHIFT cycle 4 -> no done pulse; seg all 7F, overflow=0; ready=1 on the first cycle after reset deasserts. A subsequent conversion of 200 completes normally.
